// File: rtl/cpu_main_fsm_pkg.sv
// Shared rv32i definitions for the multi-cycle sequencer: FSM states,
// write-back source select, base opcodes and the native datapath width.
package cpu_main_fsm_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned OPCODE_W    = 7;
  localparam int unsigned REG_IDX_W   = 5;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/cpu_wb_decode.sv
// Combinational opcode/rd decoder: register-file write enable, write-back
// source and the control-flow / memory class flags used by the sequencer.
module cpu_wb_decode
  import cpu_main_fsm_pkg::*;
(
  input  opcode_t                opcode,
  input  logic [REG_IDX_W-1:0]   rd,
  output logic                   rf_we_c,
  output wb_sel_t                wb_sel_c,
  output logic                   is_jump_c,
  output logic                   is_jalr_c,
  output logic                   is_branch_c,
  output logic                   is_mem_c,
  output logic                   is_store_c
);

  logic writes_rd;

  // Classify the opcode; anything unrecognised behaves as a NOP
  always_comb begin
    writes_rd   = 1'b0;
    wb_sel_c    = WB_ALU;
    is_jump_c   = 1'b0;
    is_jalr_c   = 1'b0;
    is_branch_c = 1'b0;
    is_mem_c    = 1'b0;
    is_store_c  = 1'b0;
    case (opcode)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      OP_JAL: begin
        writes_rd = 1'b1;
        wb_sel_c  = WB_PC4;
        is_jump_c = 1'b1;
      end
      OP_JALR: begin
        writes_rd = 1'b1;
        wb_sel_c  = WB_PC4;
        is_jump_c = 1'b1;
        is_jalr_c = 1'b1;
      end
      OP_LOAD: begin
        writes_rd = 1'b1;
        wb_sel_c  = WB_MEM;
        is_mem_c  = 1'b1;
      end
      OP_STORE: begin
        is_mem_c   = 1'b1;
        is_store_c = 1'b1;
      end
      OP_BRANCH: is_branch_c = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

  // x0 is hardwired, so a write to it is suppressed here
  assign rf_we_c = writes_rd && (rd != '0);

endmodule

// File: rtl/cpu_main_fsm.sv
// Multi-cycle rv32i sequencer: owns PC and IR, runs the instruction/data
// memory handshakes, and takes every PC sum from the registered ALU result.
// Optional feature: define MISALIGN_TRAP_EN to trap on misaligned jump or
// taken-branch targets (adds TRAP state and the trap output).
module cpu_main_fsm
  import cpu_main_fsm_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000)
) (
  input  logic                   clk,
  input  logic                   rst,
  output state_t                 current_state,
  output logic [DATA_WIDTH-1:0]  current_pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output opcode_t                opcode,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_WIDTH-1:0]  dmem_addr,
  input  logic [DATA_WIDTH-1:0]  dmem_rdata,
  input  logic                   dmem_ready,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic                   branch_taken,
  output logic [DATA_WIDTH-1:0]  load_data,
  output logic                   rf_we,
`ifdef MISALIGN_TRAP_EN
  output logic                   trap,
`endif
  output wb_sel_t                wb_sel
);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [DATA_WIDTH-1:0]   pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0]   target_q, target_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
`ifdef MISALIGN_TRAP_EN
  logic                    misalign_q, misalign_d;
`endif

  logic    dec_rf_we;
  wb_sel_t dec_wb_sel;
  logic    is_jump, is_jalr, is_branch, is_mem, is_store;
  logic    take_target;

  // Instruction field views of the IR
  assign opcode = opcode_t'(instr_q[OPCODE_W-1:0]);
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  // Write-back controls and instruction class from the latched instruction
  cpu_wb_decode u_wb_decode (
    .opcode      (opcode),
    .rd          (instr_q[11:7]),
    .rf_we_c     (dec_rf_we),
    .wb_sel_c    (dec_wb_sel),
    .is_jump_c   (is_jump),
    .is_jalr_c   (is_jalr),
    .is_branch_c (is_branch),
    .is_mem_c    (is_mem),
    .is_store_c  (is_store)
  );

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pc_plus4_q  <= '0;
      target_q    <= '0;
      load_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      target_q    <= target_d;
      load_data_q <= load_data_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Next-state, register updates and state-decoded handshake outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    target_d    = target_q;
    load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    rf_we       = 1'b0;
    take_target = is_jump || (is_branch && branch_taken);

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // ALU produced PC+4 during FETCH
        pc_plus4_d = alu_result;
        state_d    = EXECUTE;
      end
      EXECUTE: begin
        if (is_jump || is_branch) begin
          target_d = alu_result;
          if (is_jalr) target_d[0] = 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_d = (target_d[1:0] != 2'b00);
`endif
        end
        state_d = is_mem ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        dmem_addr = alu_result;
        if (dmem_ready) begin
          load_data_d = dmem_rdata;
          state_d     = WRITEBACK;
        end
      end
      WRITEBACK: begin
        rf_we = dec_rf_we;
`ifdef MISALIGN_TRAP_EN
        if (take_target && misalign_q) begin
          rf_we   = 1'b0;
          state_d = TRAP;
        end else begin
          pc_d    = take_target ? target_q : pc_plus4_q;
          state_d = FETCH;
        end
`else
        pc_d    = take_target ? {target_q[DATA_WIDTH-1:2], 2'b00} : pc_plus4_q;
        state_d = FETCH;
`endif
      end
`ifdef MISALIGN_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign current_state = state_q;
  assign current_pc    = pc_q;
  assign instr         = instr_q;
  assign imem_addr     = pc_q;
  assign load_data     = load_data_q;
  assign wb_sel        = dec_wb_sel;
`ifdef MISALIGN_TRAP_EN
  assign trap          = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_cpu_main_fsm.sv
// Randomized bench for cpu_main_fsm: the bench plays instruction memory,
// data memory and ALU, and predicts the state sequence, handshakes and
// architectural PC from the instruction-level rules.
module tb_cpu_main_fsm;
  import cpu_main_fsm_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  state_t      current_state;
  logic [31:0] current_pc, instr, imem_addr, imem_rdata;
  opcode_t     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_rdata, alu_result, load_data;
  logic        branch_taken, rf_we;
  wb_sel_t     wb_sel;
`ifdef MISALIGN_TRAP_EN
  logic        trap;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_load;
  logic        m_trapped;

  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                           7'h63, 7'h03, 7'h23, 7'h0F, 7'h73, 7'h7F};

  cpu_main_fsm #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .current_state (current_state),
    .current_pc    (current_pc),
    .instr         (instr),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .alu_result    (alu_result),
    .branch_taken  (branch_taken),
    .load_data     (load_data),
    .rf_we         (rf_we),
`ifdef MISALIGN_TRAP_EN
    .trap          (trap),
`endif
    .wb_sel        (wb_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Noise on inputs that the current phase must ignore
  task automatic scramble();
    imem_ready   = 1'($urandom);
    imem_rdata   = $urandom;
    dmem_ready   = 1'($urandom);
    dmem_rdata   = $urandom;
    branch_taken = 1'($urandom);
    alu_result   = $urandom;
  endtask

  // One instruction from fetch to write-back, with fw fetch and mw memory wait cycles
  task automatic run_instr(input logic [31:0] iw, input int fw, input logic [31:0] ex_val,
                           input int mw, input logic taken, input logic [31:0] rdata);
    logic [6:0]  op;
    logic        is_mem, is_jmp, take, exp_we, will_trap;
    logic [1:0]  exp_sel;
    logic [31:0] tgt, pc4;
    op      = iw[6:0];
    is_mem  = (op == 7'h03) || (op == 7'h23);
    is_jmp  = (op == 7'h6F) || (op == 7'h67);
    take    = is_jmp || ((op == 7'h63) && taken);
    exp_we  = (op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03}) && (iw[11:7] != 5'd0);
    exp_sel = (op == 7'h03) ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
    pc4     = m_pc + 32'd4;
    tgt     = ex_val;
    if (op == 7'h67) tgt[0] = 1'b0;
    will_trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    will_trap = take && (tgt[1:0] != 2'b00);
    if (will_trap) exp_we = 1'b0;
`else
    tgt[1:0] = 2'b00;
`endif

    for (int k = 0; k <= fw; k++) begin
      scramble();
      imem_ready = (k == fw);
      if (k == fw) imem_rdata = iw;
      @(negedge clk);
      chk("fetch_state", 32'(current_state), 32'(FETCH));
      chk("imem_req", 32'(imem_req), 32'd1);
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_dmem_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
    end

    scramble();
    alu_result = pc4;
    @(negedge clk);
    chk("decode_state", 32'(current_state), 32'(DECODE));
    chk("instr", instr, iw);
    chk("opcode", 32'(opcode), 32'(iw[6:0]));
    chk("funct3", 32'(funct3), 32'(iw[14:12]));
    chk("funct7", 32'(funct7), 32'(iw[31:25]));
    chk("decode_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;

    scramble();
    alu_result = ex_val;
    @(negedge clk);
    chk("exec_state", 32'(current_state), 32'(EXECUTE));
    @(posedge clk); #1;

    if (is_mem) begin
      for (int k = 0; k <= mw; k++) begin
        scramble();
        alu_result = ex_val;
        dmem_ready = (k == mw);
        if (k == mw) dmem_rdata = rdata;
        @(negedge clk);
        chk("mem_state", 32'(current_state), 32'(MEMORY));
        chk("dmem_req", 32'(dmem_req), 32'd1);
        chk("dmem_we", 32'(dmem_we), 32'(op == 7'h23));
        chk("dmem_addr", dmem_addr, ex_val);
        @(posedge clk); #1;
      end
      m_load = rdata;
    end

    scramble();
    branch_taken = taken;
    @(negedge clk);
    chk("wb_state", 32'(current_state), 32'(WRITEBACK));
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    chk("wb_sel", 32'(wb_sel), 32'(exp_sel));
    chk("load_data", load_data, m_load);
    chk("wb_dmem_req", 32'(dmem_req), 32'd0);
    chk("wb_pc", current_pc, m_pc);
    @(posedge clk); #1;
    if (will_trap) m_trapped = 1'b1;
    else           m_pc = take ? tgt : pc4;
  endtask

  initial begin
    logic [31:0] iw, ex;
    logic [6:0]  op;
    rst = 1'b1;
    m_trapped = 1'b0;
    scramble();
    #23;
    @(negedge clk);
    chk("rst_state", 32'(current_state), 32'(FETCH));
    chk("rst_pc", current_pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'(WB_ALU));
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = RST_PC;
    m_load = 32'd0;

    // Directed: ADDI, slow LW, branches both ways, JALR, rd=x0, unknown opcode
    run_instr(32'h0050_0093, 1, 32'd5, 0, 1'b0, 32'd0);
    chk("addi_pc", current_pc, 32'h4);
    run_instr(32'h0000_2103, 0, 32'h100, 3, 1'b0, 32'hDEAD_BEEF);
    chk("lw_load_data", load_data, 32'hDEAD_BEEF);
    run_instr(32'h0000_00EF, 0, 32'h20, 0, 1'b0, 32'd0);
    run_instr(32'h0000_0063, 0, 32'h40, 0, 1'b1, 32'd0);
    chk("beq_taken_pc", current_pc, 32'h40);
    run_instr(32'h0000_00EF, 0, 32'h20, 0, 1'b0, 32'd0);
    run_instr(32'h0000_0063, 0, 32'h40, 0, 1'b0, 32'd0);
    chk("beq_not_taken_pc", current_pc, 32'h24);
    run_instr(32'h0000_80E7, 0, 32'h1235, 0, 1'b0, 32'd0);
    chk("jalr_pc", current_pc, 32'h1234);
    run_instr(32'h0020_8033, 2, 32'h77, 0, 1'b1, 32'd0);
    run_instr(32'h0000_0FFF, 0, 32'h99, 0, 1'b1, 32'd0);
    chk("unknown_pc", current_pc, 32'h123C);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      iw = $urandom;
      op = ops[$urandom_range(0, 11)];
      iw[6:0] = op;
      if ($urandom_range(0, 3) == 0) iw[11:7] = 5'd0;
      ex = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (op inside {7'h6F, 7'h67, 7'h63}) begin
        ex[1] = 1'b0;
        if (op != 7'h67) ex[0] = 1'b0;
      end
`endif
      run_instr(iw, $urandom_range(0, 3), ex, $urandom_range(0, 3),
                1'($urandom), $urandom);
    end

    // Reset while a load is waiting in MEMORY
    scramble();
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_2103;
    @(posedge clk); #1;
    scramble();
    alu_result = m_pc + 32'd4;
    @(posedge clk); #1;
    scramble();
    alu_result = 32'h200;
    @(posedge clk); #1;
    scramble();
    dmem_ready = 1'b0;
    alu_result = 32'h200;
    @(negedge clk);
    chk("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_state", 32'(current_state), 32'(FETCH));
    chk("mid_rst_pc", current_pc, RST_PC);
    chk("mid_rst_imem_req", 32'(imem_req), 32'd1);
    chk("mid_rst_imem_addr", imem_addr, RST_PC);
    @(posedge clk); #1;
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    rst = 1'b0;
    m_pc = RST_PC;
    m_load = 32'd0;
    run_instr(32'h0050_0093, 0, 32'd5, 0, 1'b0, 32'd0);
    chk("post_rst_pc", current_pc, RST_PC + 32'd4);

`ifdef MISALIGN_TRAP_EN
    // Misaligned JALR target parks the core in TRAP with PC held
    run_instr(32'h0000_80E7, 0, 32'h1236, 0, 1'b0, 32'd0);
    chk("trap_flagged", 32'(m_trapped), 32'd1);
    for (int k = 0; k < 3; k++) begin
      scramble();
      @(negedge clk);
      chk("trap_state", 32'(current_state), 32'(TRAP));
      chk("trap_out", 32'(trap), 32'd1);
      chk("trap_pc", current_pc, m_pc);
      chk("trap_rf_we", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
